// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues word reads on the imem valid/ready channel,
// buffers in-order responses with their PC and presents {inst, pc, err} to decode.
// Redirect flushes the queue; responses still in flight are counted and dropped.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect pulses
// fetch_fault and parks the fetcher in HALT until an aligned redirect).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_err,
  input  logic        out_ready,
  output logic        fetch_fault
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     q_pc   [QDEPTH];
  logic [31:0]     q_inst [QDEPTH];
  logic            q_err  [QDEPTH];
  logic [QDEPTH-1:0] q_filled;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   fill_ptr;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   pend_cnt;
  logic [CW-1:0]   discard_cnt;
  logic [CW:0]     in_use;
  logic            accept;
  logic            fill;
  logic            drop;
  logic            pop;

  // Request gating, handshake qualifiers and the head-of-queue view toward decode
  always_comb begin
    in_use         = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
    imem_req_valid = (state == RUN) && fetch_en && (in_use < QD) && !redirect_valid;
    imem_req_addr  = pc;
    accept         = imem_req_valid && imem_req_ready;
    drop           = imem_rsp_valid && (discard_cnt != '0);
    fill           = imem_rsp_valid && (discard_cnt == '0);
    out_valid      = (alloc_cnt != '0) && q_filled[head];
    out_inst       = q_inst[head];
    out_pc         = q_pc[head];
    out_err        = q_err[head];
    pop            = out_valid && out_ready && !redirect_valid;
  end

  // Queue slots, pointers, PC and discard bookkeeping; redirect flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      discard_cnt <= '0;
      q_filled    <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
        q_err[i]  <= 1'b0;
      end
    end else if (redirect_valid) begin
      pc        <= redirect_pc & 32'hFFFF_FFFC;
      head      <= '0;
      tail      <= '0;
      fill_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      q_filled  <= '0;
      // A response arriving now retires either one discard or one flushed pending slot
      discard_cnt <= discard_cnt + pend_cnt - CW'(imem_rsp_valid);
    end else begin
      if (accept) begin
        q_pc[tail] <= pc;
        pc         <= pc + 32'd4;
        tail       <= tail + AW'(1);
      end
      if (fill) begin
        q_inst[fill_ptr]   <= imem_rsp_data;
        q_err[fill_ptr]    <= imem_rsp_err;
        q_filled[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + AW'(1);
      end
      if (drop) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
      if (pop) begin
        q_filled[head] <= 1'b0;
        head           <= head + AW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(accept) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(accept) - CW'(fill);
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // RUN/HALT control with a registered one-cycle misaligned-redirect fault pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= 1'b0;
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) begin
          state       <= HALT;
          fetch_fault <= 1'b1;
        end else begin
          state <= RUN;
        end
      end
    end
  end
`else
  // Without alignment checking the fetcher never leaves RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= RUN;
    end
  end

  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard of expected decode outputs
// and a monitor that checks every handshake toward decode.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;
  logic        out_ready;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          pop_log[$];
  int          cyc;
  int          n_tests;
  int          n_fail;

  logic [31:0] mem_q[$];
  logic        rsp_en;
  logic        err_en;
  logic [31:0] err_addr;
  logic        m_acc;
  logic [31:0] m_addr;
  logic        m_took;
  logic        m_en;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_err       (out_err),
    .out_ready     (out_ready),
    .fetch_fault   (fetch_fault)
  );

  // Memory contents: upper half a fixed tag, lower half the address
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Instruction memory: records accepts, answers in order one cycle later
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      m_acc  = rst_n && imem_req_valid && imem_req_ready;
      m_addr = imem_req_addr;
      m_took = imem_rsp_valid;
      m_en   = rsp_en;
      @(posedge clk);
      #1;
      if (m_took) void'(mem_q.pop_front());
      if (m_acc) mem_q.push_back(m_addr);
      if (m_en && mem_q.size() != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(mem_q[0]);
        imem_rsp_err   = err_en && (mem_q[0] == err_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
      end
    end
  end

  // Monitor: every decode handshake outside a redirect cycle must match the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
        pop_log.push_back(cyc);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got pc=%h inst=%h err=%b, required no output",
                   out_pc, out_inst, out_err);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_pc !== mon_e.pc || out_inst !== mon_e.inst || out_err !== mon_e.err) begin
            n_fail++;
            $display("FAIL pop_data: got pc=%h inst=%h err=%b, required pc=%h inst=%h err=%b",
                     out_pc, out_inst, out_err, mon_e.pc, mon_e.inst, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic err);
    exp_t e;
    e.pc   = pc;
    e.inst = inst_of(pc);
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Enable fetch until n requests are accepted, then drop fetch_en
  task automatic run_fetch(input int unsigned n, input string name);
    int unsigned issued;
    int unsigned guard;
    issued   = 0;
    guard    = 0;
    fetch_en = 1'b1;
    while (issued < n && guard < 200) begin
      #1;
      if (imem_req_valid && imem_req_ready) issued++;
      guard++;
      next_cycle();
      if (issued == n) fetch_en = 1'b0;
    end
    fetch_en = 1'b0;
    check(name, issued, n);
  endtask

  task automatic drain(input string name);
    int unsigned guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      next_cycle();
      guard++;
    end
    repeat (4) next_cycle();
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_redirect(input logic [31:0] target, input string name);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    check(name, {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int unsigned cnt;
    int          span;
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    rsp_en         = 1'b1;
    err_en         = 1'b0;
    err_addr       = '0;

    // Reset state
    repeat (2) next_cycle();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    rst_n = 1'b1;

    // Streaming: 8 sequential fetches, one instruction per cycle once filled
    out_ready = 1'b1;
    pop_log.delete();
    for (int i = 0; i < 8; i++) expect_out(32'(i * 4), 1'b0);
    run_fetch(8, "stream_issue");
    drain("stream_drain");
    check("stream_pops", pop_log.size(), 8);
    span = (pop_log.size() >= 2) ? pop_log[pop_log.size() - 1] - pop_log[0] : 0;
    check("stream_back_to_back", span, 7);

    // Backpressure: decode stalled, queue fills to 4, then drains in order
    out_ready = 1'b0;
    fetch_en  = 1'b1;
    cnt       = 0;
    repeat (10) begin
      #1;
      if (imem_req_valid && imem_req_ready) cnt++;
      next_cycle();
    end
    check("bp_accepts", cnt, 4);
    #1;
    check("bp_full_noreq", {31'b0, imem_req_valid}, 32'd0);
    check("bp_head_valid", {31'b0, out_valid}, 32'd1);
    check("bp_head_pc", out_pc, 32'h20);
    for (int i = 0; i < 8; i++) expect_out(32'h20 + 32'(i * 4), 1'b0);
    out_ready = 1'b1;
    run_fetch(4, "bp_resume_issue");
    drain("bp_drain");

    // Redirect with two requests in flight: stale responses dropped
    rsp_en = 1'b0;
    run_fetch(2, "redir_inflight_issue");
    fetch_en = 1'b1;
    do_redirect(32'h100, "redir_cycle_noreq");
    rsp_en = 1'b1;
    #1;
    check("redir_next_valid", {31'b0, imem_req_valid}, 32'd1);
    check("redir_next_addr", imem_req_addr, 32'h100);
    expect_out(32'h100, 1'b0);
    expect_out(32'h104, 1'b0);
    expect_out(32'h108, 1'b0);
    run_fetch(3, "redir_new_issue");
    drain("redir_drain");

    // Redirect coinciding with a response and a pop
    rsp_en = 1'b0;
    run_fetch(3, "rrp_issue");
    rsp_en = 1'b1;
    cnt    = 0;
    while (!(out_valid && imem_rsp_valid) && cnt < 20) begin
      next_cycle();
      #1;
      cnt++;
    end
    check("rrp_found", {31'b0, out_valid && imem_rsp_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("rrp_queue_empty", {31'b0, out_valid}, 32'd0);
    expect_out(32'h200, 1'b0);
    expect_out(32'h204, 1'b0);
    run_fetch(2, "rrp_new_issue");
    drain("rrp_drain");

    // Access fault on the third response
    do_redirect(32'h0, "err_redir_noreq");
    err_en   = 1'b1;
    err_addr = 32'h8;
    expect_out(32'h0, 1'b0);
    expect_out(32'h4, 1'b0);
    expect_out(32'h8, 1'b1);
    expect_out(32'hC, 1'b0);
    run_fetch(4, "err_issue");
    drain("err_drain");
    err_en = 1'b0;

    // PC wrap, with request held stable while memory is not ready
    do_redirect(32'hFFFF_FFF8, "wrap_redir_noreq");
    imem_req_ready = 1'b0;
    fetch_en       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("hold_addr", imem_req_addr, 32'hFFFF_FFF8);
      next_cycle();
    end
    imem_req_ready = 1'b1;
    expect_out(32'hFFFF_FFF8, 1'b0);
    expect_out(32'hFFFF_FFFC, 1'b0);
    expect_out(32'h0000_0000, 1'b0);
    run_fetch(3, "wrap_issue");
    drain("wrap_drain");

    // Misaligned redirect
    fetch_en = 1'b1;
    do_redirect(32'h102, "mis_redir_noreq");
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_fault_pulse", {31'b0, fetch_fault}, 32'd1);
    check("mis_halt_noreq", {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    #1;
    check("mis_fault_clear", {31'b0, fetch_fault}, 32'd0);
    check("mis_halt_noreq2", {31'b0, imem_req_valid}, 32'd0);
    do_redirect(32'h104, "mis_realign_noreq");
    #1;
    check("mis_resume_valid", {31'b0, imem_req_valid}, 32'd1);
    check("mis_resume_addr", imem_req_addr, 32'h104);
    expect_out(32'h104, 1'b0);
    expect_out(32'h108, 1'b0);
`else
    check("mis_no_fault", {31'b0, fetch_fault}, 32'd0);
    check("mis_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("mis_req_addr", imem_req_addr, 32'h100);
    expect_out(32'h100, 1'b0);
    expect_out(32'h104, 1'b0);
`endif
    run_fetch(2, "mis_issue");
    drain("mis_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
